// File: rtl/bus_master_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_master_port_pkg
//  Purpose  : Shared serial-bus widths, transaction mode encoding and a small
//             helper used by the master port and its serializer.
//  Revision : 1.0  initial release
// ============================================================================
package bus_master_port_pkg;

   // Default widths of the serial system bus fields.
   localparam int c_DEVICE_ADDR_WIDTH = 4;
   localparam int c_MEM_ADDR_WIDTH    = 12;
   localparam int c_DATA_WIDTH        = 8;
   localparam int c_ACK_TIMEOUT       = 8;

   // Transaction type as seen by the decoder and slave port on mmode.
   localparam logic c_MODE_READ  = 1'b0;
   localparam logic c_MODE_WRITE = 1'b1;

   // Serial bits sent after the decoder ack: address only for reads,
   // address followed by write data for writes.
   function automatic int payload_bits(input logic write, input int mem_w, input int data_w);
      return (write == c_MODE_WRITE) ? (mem_w + data_w) : mem_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_serializer
//  Purpose  : Loadable LSB-first parallel-in/serial-out shifter with a bit
//             counter and a flag marking the final bit of the loaded word.
//  Revision : 1.0  initial release
// ============================================================================
module bus_serializer #(
   parameter int WIDTH = 20,
   parameter int CNT_W = $clog2(WIDTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic [CNT_W-1:0] nbits,
   input  logic             shift,
   output logic             dout,
   output logic             last
);

   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_nbits;

   // Load a new word (restarting the bit count) or shift one bit out per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_nbits <= '0;
      end else if (load) begin
         r_shift <= din;
         r_cnt   <= '0;
         r_nbits <= nbits;
      end else if (shift) begin
         r_shift <= {1'b0, r_shift[WIDTH-1:1]};
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign dout = r_shift[0];
   assign last = (r_cnt == (r_nbits - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : bus_master_port
//  Purpose  : Master-side serial bus port. Takes one parallel request, wins
//             the bus, sends device address, waits for the decoder ack, sends
//             memory address (and write data), then collects write completion
//             or serial read data. Slave splits are resumed on re-grant.
//  Revision : 1.0  initial release
// ============================================================================
module bus_master_port
   import bus_master_port_pkg::*;
#(
   parameter int DEVICE_ADDR_WIDTH = c_DEVICE_ADDR_WIDTH,
   parameter int MEM_ADDR_WIDTH    = c_MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH        = c_DATA_WIDTH,
   parameter int ACK_TIMEOUT       = c_ACK_TIMEOUT
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dreq,
   output logic                         dready,
   input  logic                         dwrite,
   input  logic [DEVICE_ADDR_WIDTH-1:0] ddev,
   input  logic [MEM_ADDR_WIDTH-1:0]    daddr,
   input  logic [DATA_WIDTH-1:0]        dwdata,
   output logic [DATA_WIDTH-1:0]        drdata,
   output logic                         ddone,
   output logic                         derr,
   output logic                         mbreq,
   input  logic                         mbgrant,
   output logic                         mwdata,
   output logic                         mvalid,
   output logic                         mmode,
   input  logic                         mack,
   input  logic                         sready,
   input  logic                         srdata,
   input  logic                         srvalid,
   input  logic                         msplit
);

   localparam int c_SER_W  = MEM_ADDR_WIDTH + DATA_WIDTH;
   localparam int c_CNT_W  = $clog2(c_SER_W + 1);
   localparam int c_TMO_W  = $clog2(ACK_TIMEOUT + 1);
   localparam int c_RCNT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(DATA_WIDTH - 1);
   localparam logic [c_CNT_W-1:0]  c_NB_DEV    = c_CNT_W'(DEVICE_ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DEV   = 3'd2,
      S_ACKW  = 3'd3,
      S_ADDR  = 3'd4,
      S_WWAIT = 3'd5,
      S_RDAT  = 3'd6,
      S_SPLIT = 3'd7
   } state_t;

   state_t                         r_state;
   state_t                         w_state_nxt;

   logic                           r_write;
   logic [DEVICE_ADDR_WIDTH-1:0]   r_dev;
   logic [MEM_ADDR_WIDTH-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]          r_wdata;
   logic                           r_mbreq;
   logic                           r_mmode;
   logic                           r_ddone;
   logic                           r_derr;
   logic [c_TMO_W-1:0]             r_tmo;
   logic [c_RCNT_W-1:0]            r_rcnt;
   logic [DATA_WIDTH-1:0]          r_rdata;

   logic                           w_accept;
   logic                           w_done;
   logic                           w_err;
   logic                           w_ack_take;
   logic                           w_rbit;
   logic                           w_ser_load;
   logic [c_SER_W-1:0]             w_ser_din;
   logic [c_CNT_W-1:0]             w_ser_nbits;
   logic                           w_ser_dout;
   logic                           w_ser_last;
   logic                           w_mvalid;
   logic [DATA_WIDTH-1:0]          w_rmask;

   // Both the device address and the address/data payload leave through the
   // same shifter; only the DEV and ADDR states drive the serial bus.
   assign w_mvalid = (r_state == S_DEV) || (r_state == S_ADDR);
   assign w_rmask  = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_rcnt;

   bus_serializer #(
      .WIDTH (c_SER_W),
      .CNT_W (c_CNT_W)
   ) u_serializer (
      .clk   (clk),
      .rst   (rst),
      .load  (w_ser_load),
      .din   (w_ser_din),
      .nbits (w_ser_nbits),
      .shift (w_mvalid),
      .dout  (w_ser_dout),
      .last  (w_ser_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus the one-cycle strobes that steer the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_ack_take  = 1'b0;
      w_rbit      = 1'b0;
      w_ser_load  = 1'b0;
      w_ser_din   = {r_wdata, r_addr};
      w_ser_nbits = c_CNT_W'(payload_bits(r_write, MEM_ADDR_WIDTH, DATA_WIDTH));
      case (r_state)
         S_IDLE: begin
            if (dreq) begin
               w_accept    = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (mbgrant) begin
               w_ser_load  = 1'b1;
               w_ser_din   = {{(c_SER_W-DEVICE_ADDR_WIDTH){1'b0}}, r_dev};
               w_ser_nbits = c_NB_DEV;
               w_state_nxt = S_DEV;
            end
         end
         S_DEV: begin
            if (w_ser_last) begin
               w_state_nxt = S_ACKW;
            end
         end
         S_ACKW: begin
            // An ack arriving in the final wait cycle still counts.
            if (mack) begin
               w_ack_take  = 1'b1;
               w_ser_load  = 1'b1;
               w_state_nxt = S_ADDR;
            end else if (r_tmo == c_TMO_LAST) begin
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ADDR: begin
            if (w_ser_last) begin
               w_state_nxt = (r_write == c_MODE_WRITE) ? S_WWAIT : S_RDAT;
            end
         end
         S_WWAIT: begin
            // Completion beats a coincident split.
            if (sready) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (msplit) begin
               w_state_nxt = S_SPLIT;
            end
         end
         S_RDAT: begin
            w_rbit = srvalid;
            if (srvalid && (r_rcnt == c_RCNT_LAST)) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (msplit) begin
               w_state_nxt = S_SPLIT;
            end
         end
         S_SPLIT: begin
            // Splits only come from WWAIT or RDAT, so the direction tells us
            // where to resume.
            if (mbgrant) begin
               w_state_nxt = (r_write == c_MODE_WRITE) ? S_WWAIT : S_RDAT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request capture, bus request/mode, completion pulses, ack timer and read SIPO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write <= 1'b0;
         r_dev   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_mbreq <= 1'b0;
         r_mmode <= c_MODE_READ;
         r_ddone <= 1'b0;
         r_derr  <= 1'b0;
         r_tmo   <= '0;
         r_rcnt  <= '0;
         r_rdata <= '0;
      end else begin
         r_ddone <= w_done;
         r_derr  <= w_err;
         if (w_accept) begin
            r_write <= dwrite;
            r_dev   <= ddev;
            r_addr  <= daddr;
            r_wdata <= dwdata;
            r_mbreq <= 1'b1;
            r_rcnt  <= '0;
         end else if (w_done) begin
            r_mbreq <= 1'b0;
            r_mmode <= c_MODE_READ;
         end
         if (w_ack_take) begin
            r_mmode <= r_write;
         end
         if (r_state == S_ACKW) begin
            r_tmo <= r_tmo + 1'b1;
         end else begin
            r_tmo <= '0;
         end
         if (w_rbit) begin
            r_rdata <= (r_rdata & ~w_rmask) | (srdata ? w_rmask : '0);
            r_rcnt  <= r_rcnt + 1'b1;
         end
      end
   end

   assign dready = (r_state == S_IDLE);
   assign mvalid = w_mvalid;
   assign mwdata = w_mvalid & w_ser_dout;
   assign mbreq  = r_mbreq;
   assign mmode  = r_mmode;
   assign ddone  = r_ddone;
   assign derr   = r_derr;
   assign drdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_master_port
//  Purpose  : Directed self-checking bench for bus_master_port with a
//             scoreboard of expected completions and serial bit streams.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_master_port;

   localparam int c_DEV_W = 4;
   localparam int c_AW    = 12;
   localparam int c_DW    = 8;
   localparam int c_TMO   = 8;

   typedef struct {
      int          nbits;
      logic [23:0] stream;
      logic        err;
      logic        is_rd;
      logic [7:0]  data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              dreq = 1'b0;
   logic              dready;
   logic              dwrite = 1'b0;
   logic [c_DEV_W-1:0] ddev = '0;
   logic [c_AW-1:0]   daddr = '0;
   logic [c_DW-1:0]   dwdata = '0;
   logic [c_DW-1:0]   drdata;
   logic              ddone;
   logic              derr;
   logic              mbreq;
   logic              mbgrant = 1'b0;
   logic              mwdata;
   logic              mvalid;
   logic              mmode;
   logic              mack = 1'b0;
   logic              sready = 1'b0;
   logic              srdata = 1'b0;
   logic              srvalid = 1'b0;
   logic              msplit = 1'b0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   bit_cnt  = 0;
   bit   mmode_seen = 1'b0;

   logic       cap_q[$];
   logic [8:0] res_q[$];
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   bus_master_port #(
      .DEVICE_ADDR_WIDTH (c_DEV_W),
      .MEM_ADDR_WIDTH    (c_AW),
      .DATA_WIDTH        (c_DW),
      .ACK_TIMEOUT       (c_TMO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dreq    (dreq),
      .dready  (dready),
      .dwrite  (dwrite),
      .ddev    (ddev),
      .daddr   (daddr),
      .dwdata  (dwdata),
      .drdata  (drdata),
      .ddone   (ddone),
      .derr    (derr),
      .mbreq   (mbreq),
      .mbgrant (mbgrant),
      .mwdata  (mwdata),
      .mvalid  (mvalid),
      .mmode   (mmode),
      .mack    (mack),
      .sready  (sready),
      .srdata  (srdata),
      .srvalid (srvalid),
      .msplit  (msplit)
   );

   // Output monitor: serial bits, completions and mode, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (mvalid) begin
         cap_q.push_back(mwdata);
         bit_cnt++;
      end
      if (ddone) res_q.push_back({derr, drdata});
      if (mmode) mmode_seen = 1'b1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk_exp(input logic wr, input logic [3:0] dev, input logic [11:0] addr,
                                   input logic [7:0] data, input logic err, input logic [7:0] rd);
      exp_t e;
      e.err   = err;
      e.is_rd = !wr && !err;
      e.data  = rd;
      if (err) begin
         e.nbits  = c_DEV_W;
         e.stream = {20'h0, dev};
      end else if (wr) begin
         e.nbits  = c_DEV_W + c_AW + c_DW;
         e.stream = {data, addr, dev};
      end else begin
         e.nbits  = c_DEV_W + c_AW;
         e.stream = {8'h0, addr, dev};
      end
      return e;
   endfunction

   // Present a request for one cycle (or leave dreq high when hold is set).
   task automatic req(input logic wr, input logic [3:0] dev, input logic [11:0] addr,
                      input logic [7:0] data, input logic err, input logic [7:0] rd,
                      input bit push, input bit hold);
      @(posedge clk); #1;
      dreq = 1'b1; dwrite = wr; ddev = dev; daddr = addr; dwdata = data;
      if (push) exp_q.push_back(mk_exp(wr, dev, addr, data, err, rd));
      if (!hold) begin
         @(posedge clk); #1;
         dreq = 1'b0;
      end
   endtask

   task automatic wait_bits(input int target, input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (bit_cnt >= target) break;
      end
      if (bit_cnt < target) chk(tag, 32'(bit_cnt), 32'(target));
   endtask

   // Decoder ack visible during the first cycle after the device address.
   task automatic ack_pulse();
      @(posedge clk); #1 mack = 1'b1;
      @(posedge clk); #1 mack = 1'b0;
   endtask

   task automatic sready_pulse(input int delay);
      repeat (delay) @(posedge clk);
      @(posedge clk); #1 sready = 1'b1;
      @(posedge clk); #1 sready = 1'b0;
   endtask

   // Slave read data, one srvalid bit every other cycle.
   task automatic send_bits(input logic [7:0] val, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         @(posedge clk); #1;
         srvalid = 1'b1; srdata = val[i];
         @(posedge clk); #1;
         srvalid = 1'b0; srdata = 1'b0;
      end
   endtask

   task automatic check_result(input string tag);
      exp_t        e;
      logic [8:0]  r;
      logic [23:0] v;
      for (int k = 0; k < 400; k++) begin
         if (res_q.size() > 0) break;
         @(negedge clk); #1;
      end
      if (res_q.size() == 0) begin
         chk({tag, "_done"}, 32'(res_q.size()), 32'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk({tag, "_expq"}, 32'(exp_q.size()), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      r = res_q.pop_front();
      chk({tag, "_derr"}, 32'(r[8]), 32'(e.err));
      if (e.is_rd) chk({tag, "_drdata"}, 32'(r[7:0]), 32'(e.data));
      v = '0;
      for (int i = 0; i < e.nbits; i++) begin
         if (cap_q.size() > 0) v[i] = cap_q.pop_front();
      end
      chk({tag, "_stream"}, 32'(v), 32'(e.stream));
   endtask

   initial begin
      int base;
      int base2;
      int t0;
      int t1;
      int k;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_dready", 32'(dready), 32'd1);
      chk("rst_mbreq", 32'(mbreq), 32'd0);
      chk("rst_serial", 32'({mvalid, mwdata, mmode}), 32'd0);
      chk("rst_done", 32'({ddone, derr}), 32'd0);
      chk("rst_drdata", 32'(drdata), 32'd0);
      rst = 1'b0;

      // T1: write dev 1, addr 0x0A5, data 0x3C, grant two cycles late.
      base = bit_cnt;
      req(1'b1, 4'h1, 12'h0A5, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk); #1;
      chk("t1_req", 32'({mbreq, dready}), 32'b10);
      repeat (2) @(posedge clk);
      #1 mbgrant = 1'b1;
      wait_bits(base + 4, "t1_dev_bits");
      ack_pulse();
      wait_bits(base + 5, "t1_addr_start");
      t0 = cyc;
      wait_bits(base + 24, "t1_data_end");
      t1 = cyc;
      chk("t1_continuous", 32'(t1 - t0), 32'd19);
      chk("t1_mmode", 32'(mmode), 32'd1);
      sready_pulse(2);
      @(negedge clk); #1;
      chk("t1_complete", 32'({ddone, derr, mbreq, dready, mmode}), 32'b10010);
      check_result("t1");

      // T2: read dev 2, slave returns 0x96 with gaps; mmode stays low.
      mmode_seen = 1'b0;
      base = bit_cnt;
      req(1'b0, 4'h2, 12'h123, 8'h00, 1'b0, 8'h96, 1'b1, 1'b0);
      wait_bits(base + 4, "t2_dev_bits");
      ack_pulse();
      wait_bits(base + 16, "t2_addr_bits");
      send_bits(8'h96, 0, 8);
      check_result("t2");
      chk("t2_mmode_low", 32'(mmode_seen), 32'd0);

      // T3: dev 3 never acked: eight wait cycles, then error pulse in the
      // first idle cycle, i.e. the ninth sample after the last device bit.
      base = bit_cnt;
      req(1'b0, 4'h3, 12'h000, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      wait_bits(base + 4, "t3_dev_bits");
      for (k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         if (ddone) break;
      end
      chk("t3_timeout_cycles", 32'(k), 32'(c_TMO + 1));
      chk("t3_idle", 32'({mbreq, dready}), 32'b01);
      check_result("t3");

      // T4: read split after three bits, grant withheld ten cycles.
      base = bit_cnt;
      req(1'b0, 4'h2, 12'h7FE, 8'h00, 1'b0, 8'h5B, 1'b1, 1'b0);
      wait_bits(base + 4, "t4_dev_bits");
      ack_pulse();
      wait_bits(base + 16, "t4_addr_bits");
      send_bits(8'h5B, 0, 3);
      msplit = 1'b1; mbgrant = 1'b0;
      @(posedge clk); #1 msplit = 1'b0;
      base2 = bit_cnt;
      repeat (5) @(negedge clk);
      #1;
      chk("t4_split_hold", 32'({mbreq, dready, mvalid}), 32'b100);
      repeat (5) @(posedge clk);
      #1 mbgrant = 1'b1;
      send_bits(8'h5B, 3, 5);
      check_result("t4");
      chk("t4_no_resend", 32'(bit_cnt), 32'(base2));

      // T5: asynchronous reset in the middle of the address phase.
      base = bit_cnt;
      req(1'b1, 4'h4, 12'hFFF, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_bits(base + 4, "t5_dev_bits");
      ack_pulse();
      wait_bits(base + 8, "t5_addr_bits");
      chk("t5_pre_reset", 32'({mbreq, mvalid, mwdata}), 32'b111);
      #1 rst = 1'b1;
      #1;
      chk("t5_async_drop", 32'({mbreq, mvalid, mwdata}), 32'b000);
      chk("t5_dready", 32'(dready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cap_q.delete();
      res_q.delete();
      exp_q.delete();

      base = bit_cnt;
      req(1'b1, 4'h5, 12'h3C3, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_bits(base + 4, "t5b_dev_bits");
      ack_pulse();
      wait_bits(base + 24, "t5b_data_bits");
      sready_pulse(1);
      check_result("t5b");

      // T6: dreq held across ddone; second request accepted in the ddone cycle.
      base = bit_cnt;
      req(1'b1, 4'h6, 12'h456, 8'h7E, 1'b0, 8'h00, 1'b1, 1'b1);
      wait_bits(base + 4, "t6_dev_bits");
      ack_pulse();
      wait_bits(base + 24, "t6_data_bits");
      @(posedge clk); #1;
      dwrite = 1'b0; ddev = 4'h3; daddr = 12'h000; dwdata = 8'h00;
      exp_q.push_back(mk_exp(1'b0, 4'h3, 12'h000, 8'h00, 1'b1, 8'h00));
      sready_pulse(0);
      @(negedge clk); #1;
      chk("t6_done_cycle", 32'({ddone, dready, mbreq}), 32'b110);
      @(negedge clk); #1;
      chk("t6_reaccept", 32'({dready, mbreq}), 32'b01);
      @(posedge clk); #1 dreq = 1'b0;
      check_result("t6_first");
      check_result("t6_second");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
